armleobus_mem_responder: RTL and testbench

ARMLEOBUS_MEM_RESPONDER -- requirements
Module: armleobus_mem_responder

---
 rtl/armleobus_mem_responder.sv | 157 +++++++++++++++
 tb/tb_armleobus_mem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/armleobus_mem_responder.sv
// ARMLEOBUS word memory target with fixed response latency and address/command checking.
// Optional error injection input enabled by ARMLEOBUS_MEM_RESPONDER_ERRINJ_EN.
module armleobus_mem_responder #(
    parameter int unsigned WORDS_LOG2 = 10,
    parameter int unsigned LATENCY    = 1,
    parameter logic [33:0] BASE_ADDR  = 34'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        transaction,
    input  logic [2:0]  cmd,
    input  logic [33:0] address,
    input  logic [31:0] wdata,
    input  logic [3:0]  wbyte_enable,
`ifdef ARMLEOBUS_MEM_RESPONDER_ERRINJ_EN
    input  logic        err_inject,
`endif
    output logic        transaction_done,
    output logic [2:0]  transaction_response,
    output logic [31:0] rdata
);

    // ARMLEOBUS command and response encodings
    localparam logic [2:0] CMD_READ               = 3'd1;
    localparam logic [2:0] CMD_WRITE              = 3'd2;
    localparam logic [2:0] RESP_SUCCESS           = 3'd0;
    localparam logic [2:0] RESP_INVALID_OPERATION = 3'd2;
    localparam logic [2:0] RESP_UNKNOWN_ADDRESS   = 3'd3;

    // One bit wider than the bus so the upper bound never wraps
    localparam logic [34:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + (35'd4 << WORDS_LOG2);

    typedef enum logic [1:0] {StIdle, StWait, StRespond} state_t;

    state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [2:0]  resp_q, resp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        accept;

    logic [2:0]  cmd_q;
    logic [33:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
`ifdef ARMLEOBUS_MEM_RESPONDER_ERRINJ_EN
    logic        err_q;
`endif

    logic [31:0] mem [0:(1 << WORDS_LOG2) - 1];

    logic                  in_range;
    logic [WORDS_LOG2-1:0] idx;
    logic [2:0]            resp_sel;
    logic                  do_write;

    assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, addr_q} < ADDR_LIMIT);
    assign idx      = WORDS_LOG2'((addr_q - BASE_ADDR) >> 2);

    always_comb begin
        resp_sel = RESP_SUCCESS;
        if (!in_range) begin
            resp_sel = RESP_UNKNOWN_ADDRESS;
        end else if (((cmd_q != CMD_READ) && (cmd_q != CMD_WRITE)) || (addr_q[1:0] != 2'b00)) begin
            resp_sel = RESP_INVALID_OPERATION;
        end
`ifdef ARMLEOBUS_MEM_RESPONDER_ERRINJ_EN
        if (err_q) begin
            resp_sel = RESP_UNKNOWN_ADDRESS;
        end
`endif
    end

    // Storage commits on the edge that enters RESPOND
    assign do_write = (state_q == StWait) && (cnt_q == 4'd0) &&
                      (resp_sel == RESP_SUCCESS) && (cmd_q == CMD_WRITE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        resp_d  = RESP_SUCCESS;
        rdata_d = 32'h0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (transaction) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(LATENCY);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRespond;
                    done_d  = 1'b1;
                    resp_d  = resp_sel;
                    if ((resp_sel == RESP_SUCCESS) && (cmd_q == CMD_READ)) begin
                        rdata_d = mem[idx];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            resp_q  <= RESP_SUCCESS;
            rdata_q <= 32'h0;
            cmd_q   <= 3'd0;
            addr_q  <= 34'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
`ifdef ARMLEOBUS_MEM_RESPONDER_ERRINJ_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            if (accept) begin
                cmd_q   <= cmd;
                addr_q  <= address;
                wdata_q <= wdata;
                be_q    <= wbyte_enable;
`ifdef ARMLEOBUS_MEM_RESPONDER_ERRINJ_EN
                err_q   <= err_inject;
`endif
            end
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign transaction_done     = done_q;
    assign transaction_response = resp_q;
    assign rdata                = rdata_q;

endmodule

// File: tb/tb_armleobus_mem_responder.sv
// Scoreboard bench: two responders (LATENCY=1 base 0, LATENCY=0 base 0x100 with 16 words).
module tb_armleobus_mem_responder;

    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;
    localparam logic [2:0] R_OK      = 3'd0;
    localparam logic [2:0] R_INV     = 3'd2;
    localparam logic [2:0] R_UNK     = 3'd3;

    typedef struct {
        logic [2:0]  resp;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trans1 = 1'b0, trans0 = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic [33:0] address = 34'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wbyte_enable = 4'h0;
    logic        err_inject = 1'b0;
    logic        done1, done0;
    logic [2:0]  resp1, resp0;
    logic [31:0] rdata1, rdata0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    armleobus_mem_responder #(.WORDS_LOG2(10), .LATENCY(1), .BASE_ADDR(34'h0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .transaction(trans1), .cmd(cmd), .address(address),
        .wdata(wdata), .wbyte_enable(wbyte_enable),
`ifdef ARMLEOBUS_MEM_RESPONDER_ERRINJ_EN
        .err_inject(err_inject),
`endif
        .transaction_done(done1), .transaction_response(resp1), .rdata(rdata1)
    );

    armleobus_mem_responder #(.WORDS_LOG2(4), .LATENCY(0), .BASE_ADDR(34'h100)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .transaction(trans0), .cmd(cmd), .address(address),
        .wdata(wdata), .wbyte_enable(wbyte_enable),
`ifdef ARMLEOBUS_MEM_RESPONDER_ERRINJ_EN
        .err_inject(1'b0),
`endif
        .transaction_done(done0), .transaction_response(resp0), .rdata(rdata0)
    );

    task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int pending(input bit w);
        return w ? q1.size() : q0.size();
    endfunction

    task automatic mon(input bit w, input logic dn, input logic [2:0] rs, input logic [31:0] rd);
        exp_t e;
        if (dn) begin
            chk(w ? "done1_expected" : "done0_expected", 34'(pending(w) != 0), 34'd1);
            if (pending(w) != 0) begin
                if (w) e = q1.pop_front(); else e = q0.pop_front();
                chk(w ? "resp1" : "resp0", 34'(rs), 34'(e.resp));
                chk(w ? "rdata1" : "rdata0", 34'(rd), 34'(e.rdata));
                chk(w ? "cycle1" : "cycle0", 34'(cyc), 34'(e.cyc));
            end
        end else begin
            chk(w ? "idle_resp1" : "idle_resp0", 34'(rs), 34'(R_OK));
            chk(w ? "idle_rdata1" : "idle_rdata0", 34'(rd), 34'h0);
            if (pending(w) != 0) begin
                if ((w ? q1[0].cyc : q0[0].cyc) <= cyc) begin
                    chk(w ? "done1_on_time" : "done0_on_time", 34'(dn), 34'd1);
                    if (w) void'(q1.pop_front()); else void'(q0.pop_front());
                end
            end
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        mon(1'b1, done1, resp1, rdata1);
        mon(1'b0, done0, resp0, rdata0);
    end

    // Called at a negedge with the target idle; returns at a negedge with the target idle.
    task automatic txn(input bit w, input logic [2:0] c, input logic [33:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic ei,
                       input logic [2:0] er, input logic [31:0] ed);
        exp_t e;
        cmd = c; address = a; wdata = d; wbyte_enable = be; err_inject = ei;
        if (w) trans1 = 1'b1; else trans0 = 1'b1;
        @(posedge clk);
        #1;
        e.resp = er; e.rdata = ed; e.cyc = cyc + (w ? 2 : 1);
        if (w) q1.push_back(e); else q0.push_back(e);
        // Scramble inputs after accept; the latched request must be used
        trans1 = 1'b0; trans0 = 1'b0;
        cmd = ~c; address = ~a; wdata = ~d; wbyte_enable = ~be; err_inject = ~ei;
        for (int i = 0; i < 12; i++) begin
            if (pending(w) == 0) break;
            @(negedge clk);
        end
        chk(w ? "drain1" : "drain0", 34'(pending(w)), 34'd0);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done1", 34'(done1), 34'd0);
        chk("rst_resp1", 34'(resp1), 34'(R_OK));
        chk("rst_rdata1", 34'(rdata1), 34'h0);
        chk("rst_done0", 34'(done0), 34'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency-1 target
        txn(1, CMD_WRITE, 34'h10, 32'hDEADBEEF, 4'hF, 0, R_OK, 32'h0);
        txn(1, CMD_READ,  34'h10, 32'h0,        4'h0, 0, R_OK, 32'hDEADBEEF);
        txn(1, CMD_WRITE, 34'h10, 32'h11223344, 4'b0101, 0, R_OK, 32'h0);
        txn(1, CMD_READ,  34'h10, 32'h0,        4'h0, 0, R_OK, 32'hDE22BE44);
        txn(1, CMD_READ,  34'h1000, 32'h0,      4'h0, 0, R_UNK, 32'h0);
        txn(1, CMD_READ,  34'h12, 32'h0,        4'h0, 0, R_INV, 32'h0);
        txn(1, CMD_READ,  34'h1002, 32'h0,      4'h0, 0, R_UNK, 32'h0);
        txn(1, CMD_WRITE, 34'h12, 32'h0BADF00D, 4'hF, 0, R_INV, 32'h0);
        txn(1, 3'd0,      34'h10, 32'h0BADF00D, 4'hF, 0, R_INV, 32'h0);
        txn(1, CMD_WRITE, 34'h1000, 32'h0BADF00D, 4'hF, 0, R_UNK, 32'h0);
        txn(1, CMD_WRITE, 34'h10, 32'hFFFFFFFF, 4'h0, 0, R_OK, 32'h0);
        txn(1, CMD_READ,  34'h10, 32'h0,        4'h0, 0, R_OK, 32'hDE22BE44);
        txn(1, CMD_WRITE, 34'hFFC, 32'h55AA55AA, 4'hF, 0, R_OK, 32'h0);
        txn(1, CMD_READ,  34'hFFC, 32'h0,       4'h0, 0, R_OK, 32'h55AA55AA);

        // Latency-0 target, non-zero base
        txn(0, CMD_WRITE, 34'h13C, 32'hA5A50F0F, 4'hF, 0, R_OK, 32'h0);
        txn(0, CMD_WRITE, 34'h100, 32'h01020304, 4'hF, 0, R_OK, 32'h0);
        txn(0, CMD_READ,  34'h0FC, 32'h0,       4'h0, 0, R_UNK, 32'h0);
        txn(0, CMD_READ,  34'h140, 32'h0,       4'h0, 0, R_UNK, 32'h0);

        // Back-to-back reads with transaction held high
        cmd = CMD_READ; address = 34'h13C; trans0 = 1'b1;
        @(posedge clk);
        #1;
        e.resp = R_OK; e.rdata = 32'hA5A50F0F; e.cyc = cyc + 1;
        q0.push_back(e);
        address = 34'h100;
        repeat (3) @(posedge clk);
        #1;
        e.resp = R_OK; e.rdata = 32'h01020304; e.cyc = cyc + 1;
        q0.push_back(e);
        trans0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (pending(0) == 0) break;
            @(negedge clk);
        end
        chk("drain_b2b", 34'(pending(0)), 34'd0);
        @(negedge clk);

        // Reset during WAIT abandons the write
        txn(1, CMD_WRITE, 34'h20, 32'hCAFEF00D, 4'hF, 0, R_OK, 32'h0);
        cmd = CMD_WRITE; address = 34'h20; wdata = 32'h12345678; wbyte_enable = 4'hF;
        trans1 = 1'b1;
        @(posedge clk);
        #2;
        trans1 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_async_done1", 34'(done1), 34'd0);
        chk("rst_async_resp1", 34'(resp1), 34'(R_OK));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        txn(1, CMD_READ, 34'h20, 32'h0, 4'h0, 0, R_OK, 32'hCAFEF00D);

`ifdef ARMLEOBUS_MEM_RESPONDER_ERRINJ_EN
        txn(1, CMD_WRITE, 34'h10, 32'h99999999, 4'hF, 1, R_UNK, 32'h0);
        txn(1, CMD_READ,  34'h10, 32'h0,        4'h0, 0, R_OK, 32'hDE22BE44);
        txn(1, CMD_READ,  34'h10, 32'h0,        4'h0, 1, R_UNK, 32'h0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
